// File: rtl/player_controller.sv
// player_controller
//   Pac-Man movement and dot-eating stage feeding the renderer. Buffers a
//   direction request from w/a/s/d, steps the player one pixel per tick
//   through the wall tilemap (horizontal tunnel wrap), owns the live dot and
//   big-dot maps, and reports score, eat pulses and level-clear.
//
//   Ports
//     clk, reset (async, active low)      clock / reset
//     tick, enable                        movement step request / game running
//     load                                copy *_init maps into the live maps
//     w, a, s, d                          direction buttons
//     tilemap_walls, dots_init, big_dots_init   ROWS*COLS maps, bit row*COLS+col
//     tilemap_dots, tilemap_big_dots      live maps
//     player_x, player_y, player_direction, moving
//     score, dot_eaten, power_eaten, level_clear
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_STEP | waiting for movement ticks
//   ST_EAT  | one cycle: consume the dot / big dot under the player tile
module player_controller #(
  parameter int COLS      = 28,
  parameter int ROWS      = 31,
  parameter int TILE_LOG2 = 3,
  parameter int START_COL = 13,
  parameter int START_ROW = 23,
  parameter int X_W       = 10,
  parameter int Y_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 w,
  input  logic                 a,
  input  logic                 s,
  input  logic                 d,
  input  logic [ROWS*COLS-1:0] tilemap_walls,
  input  logic [ROWS*COLS-1:0] dots_init,
  input  logic [ROWS*COLS-1:0] big_dots_init,
  output logic [ROWS*COLS-1:0] tilemap_dots,
  output logic [ROWS*COLS-1:0] tilemap_big_dots,
  output logic [X_W-1:0]       player_x,
  output logic [Y_W-1:0]       player_y,
  output logic [1:0]           player_direction,
  output logic                 moving,
  output logic [15:0]          score,
  output logic                 dot_eaten,
  output logic                 power_eaten,
  output logic                 level_clear
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  localparam logic [X_W-1:0] X_MAX   = X_W'((COLS << TILE_LOG2) - 1);
  localparam logic [X_W-1:0] X_START = X_W'(START_COL << TILE_LOG2);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_ROW << TILE_LOG2);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {ST_STEP, ST_EAT} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] py_q, py_d;
  logic [1:0]     dir_q, dir_d;
  logic [1:0]     pend_q, pend_d;
  logic           moving_q, moving_d;
  logic           land_q, land_d;
  logic [N-1:0]   dots_q, dots_d;
  logic [N-1:0]   big_q, big_d;
  logic [15:0]    score_q, score_d;
  logic           dot_ev_q, dot_ev_d;
  logic           pow_ev_q, pow_ev_d;
  logic [9:0]     dots_left_q, dots_left_d;
  logic           pop_pend_q, pop_pend_d;
  logic           loaded_q, loaded_d;

  // True when the tile next to (col,row) in direction dir is a wall.
  // Columns wrap for the tunnel; rows outside the maze are solid.
  function automatic logic blocked(input logic [1:0] dir, input int col,
                                   input int row, input logic [N-1:0] walls);
    int c;
    int r;
    c = col;
    r = row;
    case (dir)
      DIR_UP:    r = row - 1;
      DIR_LEFT:  c = (col == 0) ? COLS - 1 : col - 1;
      DIR_DOWN:  r = row + 1;
      default:   c = (col >= COLS - 1) ? 0 : col + 1;
    endcase
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b1;
    return walls[IDX_W'(r * COLS + c)];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_STEP;
      px_q        <= X_START;
      py_q        <= Y_START;
      dir_q       <= DIR_LEFT;
      pend_q      <= DIR_LEFT;
      moving_q    <= 1'b0;
      land_q      <= 1'b0;
      dots_q      <= '0;
      big_q       <= '0;
      score_q     <= '0;
      dot_ev_q    <= 1'b0;
      pow_ev_q    <= 1'b0;
      dots_left_q <= '0;
      pop_pend_q  <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      moving_q    <= moving_d;
      land_q      <= land_d;
      dots_q      <= dots_d;
      big_q       <= big_d;
      score_q     <= score_d;
      dot_ev_q    <= dot_ev_d;
      pow_ev_q    <= pow_ev_d;
      dots_left_q <= dots_left_d;
      pop_pend_q  <= pop_pend_d;
      loaded_q    <= loaded_d;
    end
  end

  int             col_i;
  int             row_i;
  logic           aligned;
  logic           step_ok;
  logic           go;
  logic [1:0]     new_dir;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [IDX_W-1:0] cur_idx;
  logic [16:0]    sum;
  logic [6:0]     add;
  logic           eat_dec;

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    moving_d    = moving_q;
    land_d      = 1'b0;
    dots_d      = dots_q;
    big_d       = big_q;
    score_d     = score_q;
    dot_ev_d    = 1'b0;
    pow_ev_d    = 1'b0;
    dots_left_d = dots_left_q;
    pop_pend_d  = 1'b0;
    loaded_d    = loaded_q;
    go          = 1'b0;
    new_dir     = dir_q;
    nx          = px_q;
    ny          = py_q;
    add         = '0;
    sum         = '0;
    eat_dec     = 1'b0;

    col_i   = int'(px_q >> TILE_LOG2);
    row_i   = int'(py_q >> TILE_LOG2);
    aligned = (px_q[TILE_LOG2-1:0] == '0) && (py_q[TILE_LOG2-1:0] == '0);
    cur_idx = IDX_W'(row_i * COLS + col_i);

    if (w)      pend_d = DIR_UP;
    else if (a) pend_d = DIR_LEFT;
    else if (s) pend_d = DIR_DOWN;
    else if (d) pend_d = DIR_RIGHT;

    // Ticks are dropped while an eat is in flight (landing cycle and EAT).
    step_ok = tick && enable && (state_q == ST_STEP) && !land_q;

    if (step_ok) begin
      go = 1'b1;
      if (aligned) begin
        if (!blocked(pend_q, col_i, row_i, tilemap_walls))
          new_dir = pend_q;
        else if (blocked(dir_q, col_i, row_i, tilemap_walls))
          go = 1'b0;
      end else if (pend_q == (dir_q ^ 2'd2)) begin
        new_dir = pend_q;
      end
      if (go) begin
        case (new_dir)
          DIR_UP:    ny = py_q - 1'b1;
          DIR_LEFT:  nx = (px_q == '0) ? X_MAX : px_q - 1'b1;
          DIR_DOWN:  ny = py_q + 1'b1;
          default:   nx = (px_q == X_MAX) ? '0 : px_q + 1'b1;
        endcase
      end
      dir_d    = new_dir;
      moving_d = go;
      px_d     = nx;
      py_d     = ny;
      land_d   = go && (nx[TILE_LOG2-1:0] == '0) && (ny[TILE_LOG2-1:0] == '0);
    end

    if (land_q) state_d = ST_EAT;

    if (state_q == ST_EAT) begin
      state_d = ST_STEP;
      if (dots_q[cur_idx]) begin
        dots_d[cur_idx] = 1'b0;
        add             = 7'd10;
        dot_ev_d        = 1'b1;
      end else if (big_q[cur_idx]) begin
        big_d[cur_idx] = 1'b0;
        add            = 7'd50;
        pow_ev_d       = 1'b1;
      end
      sum     = {1'b0, score_q} + 17'(add);
      score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // A load overrides any eat landing in the same cycle.
    if (load) begin
      dots_d     = dots_init;
      big_d      = big_dots_init;
      score_d    = score_q;
      dot_ev_d   = 1'b0;
      pow_ev_d   = 1'b0;
      state_d    = ST_STEP;
      pop_pend_d = 1'b1;
      loaded_d   = 1'b1;
    end

    eat_dec = dot_ev_d | pow_ev_d;
    if (pop_pend_q)
      dots_left_d = 10'($countones(dots_q) + $countones(big_q)) - {9'b0, eat_dec};
    else if (eat_dec && dots_left_q != '0)
      dots_left_d = dots_left_q - 1'b1;
  end

  assign tilemap_dots     = dots_q;
  assign tilemap_big_dots = big_q;
  assign player_x         = px_q;
  assign player_y         = py_q;
  assign player_direction = dir_q;
  assign moving           = moving_q;
  assign score            = score_q;
  assign dot_eaten        = dot_ev_q;
  assign power_eaten      = pow_ev_q;
  // Held low while a freshly loaded count is still being computed.
  assign level_clear      = loaded_q && !pop_pend_q && (dots_left_q == '0);

endmodule

// File: tb/tb_player_controller.sv
// tb_player_controller
//   Directed bench for player_controller: reset state, dot eating and its
//   pulse timing, wall blocking, reversal, tunnel wrap, score saturation and
//   load overriding an eat.
module tb_player_controller;

  localparam int COLS = 28;
  localparam int ROWS = 31;
  localparam int N    = ROWS * COLS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick, enable, load;
  logic         bw, ba, bs, bd;
  logic [N-1:0] walls, dots_init, big_init;
  logic [N-1:0] dots_map, big_map;
  logic [9:0]   px, py;
  logic [1:0]   dir;
  logic         moving;
  logic [15:0]  score;
  logic         dot_eaten, power_eaten, level_clear;

  int n_chk  = 0;
  int n_pass = 0;
  int pow_cnt = 0;

  always #5 clk = ~clk;

  player_controller dut (
    .clk(clk), .reset(rst_n), .tick(tick), .enable(enable), .load(load),
    .w(bw), .a(ba), .s(bs), .d(bd),
    .tilemap_walls(walls), .dots_init(dots_init), .big_dots_init(big_init),
    .tilemap_dots(dots_map), .tilemap_big_dots(big_map),
    .player_x(px), .player_y(py), .player_direction(dir), .moving(moving),
    .score(score), .dot_eaten(dot_eaten), .power_eaten(power_eaten),
    .level_clear(level_clear)
  );

  always @(negedge clk) if (power_eaten) pow_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; load = 1'b0; enable = 1'b1;
    bw = 1'b0; ba = 1'b0; bs = 1'b0; bd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      0: bw = 1'b1;
      1: ba = 1'b1;
      2: bs = 1'b1;
      default: bd = 1'b1;
    endcase
    @(negedge clk);
    bw = 1'b0; ba = 1'b0; bs = 1'b0; bd = 1'b0;
    @(negedge clk);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic load_maps(input logic [N-1:0] dm, input logic [N-1:0] bm);
    dots_init = dm;
    big_init  = bm;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] row23;
    walls = '0; dots_init = '0; big_init = '0;
    row23 = '0;
    for (int c = 0; c < COLS; c++) row23[23*COLS + c] = 1'b1;

    // Reset state
    do_reset();
    chk("rst_px", px, 104);
    chk("rst_py", py, 184);
    chk("rst_dir", dir, 1);
    chk("rst_moving", moving, 0);
    chk("rst_score", score, 0);
    chk("rst_lclear", level_clear, 0);
    chk("rst_dots", dots_map, 0);

    // Single dot at row 23 col 12, walk left onto it
    do_reset();
    begin
      logic [N-1:0] m;
      m = '0;
      m[23*COLS + 12] = 1'b1;
      load_maps(m, '0);
    end
    chk("ld_lclear", level_clear, 0);
    chk("ld_dotbit", dots_map[23*COLS + 12], 1);
    press(1);
    step(7);
    chk("dot_px7", px, 97);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("dot_px8", px, 96);
    chk("dot_pulse_e0", dot_eaten, 0);
    @(negedge clk);
    chk("dot_pulse_e1", dot_eaten, 0);
    chk("dot_bit_e1", dots_map[23*COLS + 12], 1);
    @(negedge clk);
    chk("dot_pulse_e2", dot_eaten, 1);
    chk("dot_bit_e2", dots_map[23*COLS + 12], 0);
    chk("dot_score", score, 10);
    @(negedge clk);
    chk("dot_pulse_e3", dot_eaten, 0);
    chk("dot_lclear", level_clear, 1);
    enable = 1'b0;
    step(1);
    chk("dis_px", px, 96);
    enable = 1'b1;

    // Wall above spawn: keep going left
    walls = '0;
    walls[22*COLS + 13] = 1'b1;
    do_reset();
    press(0);
    step(1);
    chk("wall_px", px, 103);
    chk("wall_py", py, 184);
    chk("wall_dir", dir, 1);
    chk("wall_moving", moving, 1);

    // Walls above and to the left: no move
    walls[23*COLS + 12] = 1'b1;
    do_reset();
    step(1);
    press(0);
    step(1);
    chk("boxed_px", px, 104);
    chk("boxed_py", py, 184);
    chk("boxed_moving", moving, 0);

    // Reversal mid-tile
    walls = '0;
    do_reset();
    step(3);
    chk("rev_px3", px, 101);
    press(3);
    step(1);
    chk("rev_dir", dir, 3);
    chk("rev_px", px, 102);

    // Tunnel wrap
    do_reset();
    press(1);
    step(104);
    chk("tun_px0", px, 0);
    step(1);
    chk("tun_px223", px, 223);
    chk("tun_dir", dir, 1);
    step(7);
    chk("tun_px216", px, 216);

    // Pump score to 65500 with big dots on row 23 (1310 eats x 50)
    do_reset();
    pow_cnt = 0;
    for (int lap = 0; lap < 46; lap++) begin
      load_maps('0, row23);
      step(224);
    end
    load_maps('0, row23);
    step(176);
    chk("pump_count", pow_cnt, 1310);
    chk("pump_score", score, 65500);

    // Load in the EAT cycle suppresses the eat
    step(7);
    pow_cnt = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ldeat_pulse", power_eaten, 0);
    chk("ldeat_score", score, 65500);
    chk("ldeat_bit", big_map[23*COLS + 18], 1);
    @(negedge clk);
    chk("ldeat_cnt", pow_cnt, 0);
    chk("ldeat_px", px, 144);

    // Next big dot saturates the score
    step(8);
    chk("sat_cnt", pow_cnt, 1);
    chk("sat_score", score, 65535);
    chk("sat_bit", big_map[23*COLS + 17], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/player_controller.md
# player_controller

Tile-aware Pac-Man movement and dot-eating stage that sits directly upstream of the renderer. It turns the w/a/s/d buttons into a buffered direction request and steps the player one pixel per movement tick through the wall tilemap, with a horizontal tunnel wrap. It owns the live dot and big-dot tilemaps that feed the renderer, and it reports score, eat events and level-clear.

## Interface
Parameters:
- COLS, 28, maze width in tiles
- ROWS, 31, maze height in tiles
- TILE_LOG2, 3, log2 of tile size in pixels (8 px tiles)
- START_COL, 13, spawn tile column
- START_ROW, 23, spawn tile row
- X_W, 10, player_x width
- Y_W, 10, player_y width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle movement enable, one pixel step per tick
- enable  in  1  game running; when low, ticks are ignored and state holds
- load  in  1  single-cycle pulse: copy the *_init maps into the live maps
- w, a, s, d  in  1 each  direction buttons, active-high
- tilemap_walls  in  ROWS*COLS  1 = wall; bit index row*COLS+col
- dots_init, big_dots_init  in  ROWS*COLS  initial dot layouts
- tilemap_dots, tilemap_big_dots  out  ROWS*COLS  live maps
- player_x  out  X_W  pixel x of the tile-origin corner
- player_y  out  Y_W  pixel y
- player_direction  out  2  0 up, 1 left, 2 down, 3 right
- moving  out  1  player advanced on the last tick
- score  out  16  saturating score
- dot_eaten, power_eaten  out  1 each  one-cycle event pulses
- level_clear  out  1  level-clear flag (see Operation)

## Operation
- Position register: px, py. Tile index is col = px>>TILE_LOG2, row = py>>TILE_LOG2. Aligned means both low TILE_LOG2 bits are 0.
- Pending direction: every cycle with any button high, latch it with priority w>a>s>d. The latch holds until consumed.
- On each tick with enable=1, the block decides in this order:
  - Aligned: neighbour(dir) = adjacent tile. The column wraps modulo COLS. A row outside 0..ROWS-1 counts as a wall.
    - If neighbour(pending) is not a wall: dir ← pending.
    - Else if neighbour(dir) is not a wall: keep dir.
    - Else: no move, moving ← 0.
  - Not aligned: if pending is the opposite of dir, dir ← pending. Otherwise keep dir. Always move.
  - A move is ±1 pixel. px wraps modulo COLS<<TILE_LOG2: 0 left → 223, 223 right → 0. py never wraps.
- FSM has two states:
  - STEP: waits for ticks.
  - EAT: entered on the cycle after a move that lands aligned.
  - In EAT, a single cycle: check the current tile.
    - If the dot bit is set: clear it, score += 10, dot_eaten = 1.
    - Else if the big-dot bit is set: clear it, score += 50, power_eaten = 1.
    - Then return to STEP. A tick arriving while in EAT is dropped.
- Score saturates at 65535.
- dots_left is a 10-bit counter of the set bits in both maps:
  - It is loaded on load.
  - It decrements on each eat.
- level_clear = 1 while dots_left = 0 and at least one load has occurred since reset.
- load takes priority over EAT in the same cycle:
  - The maps are reloaded and dots_left is recomputed.
  - No score is added.
  - The FSM returns to STEP.

## Timing
- Reset values:
  - px = START_COL<<TILE_LOG2 (104), py = START_ROW<<TILE_LOG2 (184).
  - player_direction = 1 (left), pending = 1, moving = 0.
  - Both maps = 0, score = 0, dots_left = 0, all pulses 0, level_clear = 0, FSM = STEP.
- Reset mid-move discards all state immediately.
- Tick to position update: 1 clk (registered).
- Landing aligned to eat pulse and map clear: 2 clks after the tick edge.
- The wall lookup is combinational from registered position. It must close at the system clock.
- load to updated maps: 1 clk. dots_left and level_clear are valid 2 clks after load; the popcount may be pipelined one stage.
- Buttons are sampled every clk. A press shorter than one clk is not guaranteed to be captured.

## Test plan
- Reset with no walls and no ticks → px=104, py=184, dir=1, score=0, level_clear=0.
- Load a map with a single dot at (23,12), press a, then 8 ticks → px=96, dot_eaten pulses once 2 clks after the 8th tick, score=10, dots_left=0, level_clear=1.
- Wall at (22,13), press w at the aligned spawn, then tick → no vertical move, continue left (px=103), dir=1.
- Reversal: after 3 left ticks (px=101), press d, then tick → dir=3, px=102.
- Tunnel: place the player at px=0 on an open row, press a, then tick → px=223; 7 more ticks → px=216.
- Big dot under the landing tile with score=65500 → power_eaten pulses and score saturates at 65535. A simultaneous load suppresses the pulse and leaves score at 65500.
